// File: rtl/rob_commit_if.sv
// rob_commit_if: allocation and CDB writeback bus into the reorder buffer
interface rob_commit_if #(parameter int TAG_W = 4);
  logic             alloc_valid;
  logic [4:0]       alloc_rd;
  logic             alloc_is_branch;
  logic             alloc_pred_taken;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_value;
  logic             cdb_taken;
  logic [31:0]      cdb_target;
  modport master (output alloc_valid, alloc_rd, alloc_is_branch, alloc_pred_taken,
                  output cdb_valid, cdb_tag, cdb_value, cdb_taken, cdb_target);
  modport slave  (input alloc_valid, alloc_rd, alloc_is_branch, alloc_pred_taken,
                  input cdb_valid, cdb_tag, cdb_value, cdb_taken, cdb_target);
endinterface

// File: rtl/rob_commit.sv
// rob_commit: in-order reorder buffer with CDB writeback, commit and mispredict flush.
// Define ROB_CDB_BYPASS_EN to let queries see same-cycle CDB data.
module rob_commit #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  rob_commit_if.slave      io,
  input  logic [TAG_W-1:0] q_tag1,
  input  logic [TAG_W-1:0] q_tag2,
  input  logic             reg_busy_commit_rd,
  input  logic [TAG_W-1:0] reg_reorder_commit_rd,
  output logic             Clear_flag,
  output logic [31:0]      redirect_pc,
  output logic             rob_full,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             q_ready1,
  output logic             q_ready2,
  output logic [31:0]      q_value1,
  output logic [31:0]      q_value2,
  output logic [4:0]       commit_rd,
  output logic             ROB_to_Reg_needchange,
  output logic [31:0]      reg_reg_commit_rd_,
  output logic             reg_busy_commit_rd_
);
  logic             busy_q [DEPTH], busy_d [DEPTH];
  logic             ready_q [DEPTH], ready_d [DEPTH];
  logic [4:0]       rd_q [DEPTH], rd_d [DEPTH];
  logic [31:0]      value_q [DEPTH], value_d [DEPTH];
  logic             is_branch_q [DEPTH], is_branch_d [DEPTH];
  logic             pred_taken_q [DEPTH], pred_taken_d [DEPTH];
  logic             taken_q [DEPTH], taken_d [DEPTH];
  logic [31:0]      target_q [DEPTH], target_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic             clear_q, clear_d;
  logic [31:0]      redirect_q, redirect_d;
  logic             live, alloc, cdb_we, commit, mispredict;

  assign live       = rdy & ~clear_q;
  assign rob_full   = count_q == (TAG_W+1)'(DEPTH);
  assign alloc      = io.alloc_valid & ~rob_full & live;
  assign cdb_we     = io.cdb_valid & busy_q[io.cdb_tag] & live;
  assign commit     = busy_q[head_q] & ready_q[head_q] & live;
  assign mispredict = commit & is_branch_q[head_q] & (taken_q[head_q] != pred_taken_q[head_q]);

  assign alloc_tag             = tail_q;
  assign commit_rd             = rd_q[head_q];
  assign ROB_to_Reg_needchange = commit & (commit_rd != 5'd0);
  assign reg_reg_commit_rd_    = value_q[head_q];
  assign reg_busy_commit_rd_   = (reg_reorder_commit_rd == head_q) ? 1'b0 : reg_busy_commit_rd;
  assign Clear_flag            = clear_q;
  assign redirect_pc           = redirect_q;

`ifdef ROB_CDB_BYPASS_EN
  logic byp1, byp2;
  assign byp1     = io.cdb_valid & busy_q[io.cdb_tag] & (q_tag1 == io.cdb_tag);
  assign byp2     = io.cdb_valid & busy_q[io.cdb_tag] & (q_tag2 == io.cdb_tag);
  assign q_ready1 = byp1 | (busy_q[q_tag1] & ready_q[q_tag1]);
  assign q_ready2 = byp2 | (busy_q[q_tag2] & ready_q[q_tag2]);
  assign q_value1 = byp1 ? io.cdb_value : value_q[q_tag1];
  assign q_value2 = byp2 ? io.cdb_value : value_q[q_tag2];
`else
  assign q_ready1 = busy_q[q_tag1] & ready_q[q_tag1];
  assign q_ready2 = busy_q[q_tag2] & ready_q[q_tag2];
  assign q_value1 = value_q[q_tag1];
  assign q_value2 = value_q[q_tag2];
`endif

  // Next state: CDB writeback, allocation at tail, commit at head; a mispredict flushes everything.
  always_comb begin
    busy_d       = busy_q;
    ready_d      = ready_q;
    rd_d         = rd_q;
    value_d      = value_q;
    is_branch_d  = is_branch_q;
    pred_taken_d = pred_taken_q;
    taken_d      = taken_q;
    target_d     = target_q;
    if (cdb_we) begin
      ready_d[io.cdb_tag]  = 1'b1;
      value_d[io.cdb_tag]  = io.cdb_value;
      taken_d[io.cdb_tag]  = io.cdb_taken;
      target_d[io.cdb_tag] = io.cdb_target;
    end
    if (alloc) begin
      busy_d[tail_q]       = 1'b1;
      ready_d[tail_q]      = 1'b0;
      rd_d[tail_q]         = io.alloc_rd;
      is_branch_d[tail_q]  = io.alloc_is_branch;
      pred_taken_d[tail_q] = io.alloc_pred_taken;
    end
    if (commit) busy_d[head_q] = 1'b0;
    if (mispredict) busy_d = '{default: 1'b0};
    head_d     = mispredict ? '0 : head_q + TAG_W'(commit);
    tail_d     = mispredict ? '0 : tail_q + TAG_W'(alloc);
    count_d    = mispredict ? '0 : count_q + (TAG_W+1)'(alloc) - (TAG_W+1)'(commit);
    clear_d    = rdy ? mispredict : clear_q;
    redirect_d = mispredict ? target_q[head_q] : redirect_q;
  end

  // State registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q       <= '{default: 1'b0};
      ready_q      <= '{default: 1'b0};
      rd_q         <= '{default: 5'd0};
      value_q      <= '{default: 32'd0};
      is_branch_q  <= '{default: 1'b0};
      pred_taken_q <= '{default: 1'b0};
      taken_q      <= '{default: 1'b0};
      target_q     <= '{default: 32'd0};
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      clear_q      <= 1'b0;
      redirect_q   <= '0;
    end else begin
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      rd_q         <= rd_d;
      value_q      <= value_d;
      is_branch_q  <= is_branch_d;
      pred_taken_q <= pred_taken_d;
      taken_q      <= taken_d;
      target_q     <= target_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      clear_q      <= clear_d;
      redirect_q   <= redirect_d;
    end
  end
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed vectors for rob_commit with hand-computed expectations
module tb_rob_commit;
  logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1;
  logic [3:0]  q_tag1 = '0, q_tag2 = '0, reg_reorder = '0;
  logic        reg_busy = 1'b0;
  logic        clear_flag, rob_full, q_ready1, q_ready2, needchange, reg_busy_o;
  logic [31:0] redirect_pc, q_value1, q_value2, reg_val;
  logic [3:0]  alloc_tag;
  logic [4:0]  commit_rd;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  rob_commit_if #(.TAG_W(4)) bus ();

  rob_commit #(.DEPTH(16), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .io(bus.slave),
    .q_tag1(q_tag1), .q_tag2(q_tag2),
    .reg_busy_commit_rd(reg_busy), .reg_reorder_commit_rd(reg_reorder),
    .Clear_flag(clear_flag), .redirect_pc(redirect_pc), .rob_full(rob_full), .alloc_tag(alloc_tag),
    .q_ready1(q_ready1), .q_ready2(q_ready2), .q_value1(q_value1), .q_value2(q_value2),
    .commit_rd(commit_rd), .ROB_to_Reg_needchange(needchange),
    .reg_reg_commit_rd_(reg_val), .reg_busy_commit_rd_(reg_busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.alloc_valid = 1'b0;
    bus.cdb_valid   = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic br, input logic pt);
    bus.alloc_valid      = 1'b1;
    bus.alloc_rd         = rd;
    bus.alloc_is_branch  = br;
    bus.alloc_pred_taken = pt;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] v, input logic tk, input logic [31:0] tg);
    bus.cdb_valid  = 1'b1;
    bus.cdb_tag    = t;
    bus.cdb_value  = v;
    bus.cdb_taken  = tk;
    bus.cdb_target = tg;
  endtask

  initial begin
    idle();
    alloc(0, 0, 0);
    bus.alloc_valid = 1'b0;
    cdb(0, 0, 0, 0);
    bus.cdb_valid = 1'b0;
    #1;
    chk("rst_full", rob_full, 0);
    chk("rst_tag", alloc_tag, 0);
    chk("rst_clear", clear_flag, 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_commit", needchange, 0);
    #11 rst = 1'b1;
    tick();
    // basic allocate / writeback / commit
    alloc(5, 0, 0);
    #1 chk("t1_tag", alloc_tag, 0);
    tick();
    idle();
    cdb(0, 32'h1234, 0, 0);
    tick();
    idle();
    reg_reorder = 0;
    reg_busy = 1'b1;
    q_tag1 = 0;
    #1;
    chk("t1_need", needchange, 1);
    chk("t1_rd", commit_rd, 5);
    chk("t1_val", reg_val, 32'h1234);
    chk("t1_busy", reg_busy_o, 0);
    chk("t1_qrdy", q_ready1, 1);
    chk("t1_qval", q_value1, 32'h1234);
    reg_reorder = 1;
    #1 chk("t1_busy_pass", reg_busy_o, 1);
    tick();
    chk("t1_after_need", needchange, 0);
    chk("t1_after_tag", alloc_tag, 1);
    // commit of rd=0 still advances head
    alloc(0, 0, 0);
    tick();
    idle();
    cdb(1, 9, 0, 0);
    tick();
    idle();
    #1;
    chk("rd0_need", needchange, 0);
    chk("rd0_rd", commit_rd, 0);
    tick();
    reg_reorder = 2;
    #1;
    chk("rd0_head", reg_busy_o, 0);
    chk("rd0_tag", alloc_tag, 2);
    // query with same-cycle CDB
    alloc(3, 0, 0);
    tick();
    alloc(3, 0, 0);
    tick();
    idle();
    cdb(3, 7, 0, 0);
    q_tag1 = 3;
    #1;
`ifdef ROB_CDB_BYPASS_EN
    chk("byp_rdy", q_ready1, 1);
    chk("byp_val", q_value1, 7);
`else
    chk("byp_rdy", q_ready1, 0);
`endif
    tick();
    idle();
    #1;
    chk("q_rdy", q_ready1, 1);
    chk("q_val", q_value1, 7);
    // mispredicted branch flushes
    alloc(7, 1, 0);
    tick();
    alloc(8, 0, 0);
    tick();
    idle();
    cdb(2, 2, 0, 0);
    tick();
    cdb(4, 32'h44, 1, 32'h80);
    tick();
    idle();
    tick();
    #1;
    chk("br_rd", commit_rd, 7);
    chk("br_need", needchange, 1);
    chk("br_val", reg_val, 32'h44);
    chk("br_clear0", clear_flag, 0);
    tick();
    alloc(9, 0, 0);
    #1;
    chk("br_clear1", clear_flag, 1);
    chk("br_redirect", redirect_pc, 32'h80);
    chk("br_full", rob_full, 0);
    chk("br_tag", alloc_tag, 0);
    chk("br_need_flush", needchange, 0);
    tick();
    idle();
    #1;
    chk("br_clear2", clear_flag, 0);
    chk("br_tag_ignored", alloc_tag, 0);
    chk("br_redirect_hold", redirect_pc, 32'h80);
    // fill to full, 17th alloc dropped
    for (int i = 0; i < 16; i++) begin
      alloc(5'(i + 1), 0, 0);
      tick();
    end
    #1;
    chk("full_flag", rob_full, 1);
    chk("full_tag", alloc_tag, 0);
    alloc(31, 0, 0);
    tick();
    chk("full_drop_tag", alloc_tag, 0);
    chk("full_drop_flag", rob_full, 1);
    // full + commit + alloc in one cycle
    idle();
    cdb(0, 32'h55, 0, 0);
    tick();
    idle();
    alloc(20, 0, 0);
    #1;
    chk("fc_full", rob_full, 1);
    chk("fc_need", needchange, 1);
    chk("fc_rd", commit_rd, 1);
    chk("fc_val", reg_val, 32'h55);
    tick();
    idle();
    #1;
    chk("fc_full_after", rob_full, 0);
    chk("fc_tag_after", alloc_tag, 0);
    alloc(21, 0, 0);
    tick();
    idle();
    #1;
    chk("fc_refill_full", rob_full, 1);
    chk("fc_refill_tag", alloc_tag, 1);
    // stall holds state and blocks commit
    cdb(1, 32'h66, 0, 0);
    tick();
    idle();
    #1;
    chk("st_need", needchange, 1);
    chk("st_rd", commit_rd, 2);
    rdy = 1'b0;
    #1 chk("st_need_stall", needchange, 0);
    tick();
    rdy = 1'b1;
    #1;
    chk("st_need_resume", needchange, 1);
    chk("st_rd_resume", commit_rd, 2);
    chk("st_val_resume", reg_val, 32'h66);
    // asynchronous reset mid-operation
    rst = 1'b0;
    #1;
    chk("ar_full", rob_full, 0);
    chk("ar_tag", alloc_tag, 0);
    chk("ar_need", needchange, 0);
    chk("ar_clear", clear_flag, 0);
    rst = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
